// File: rtl/i2c_target_regs_if.sv
// I2C target bus pins plus the local host read port and the write-commit strobe.
interface i2c_target_regs_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave  (input  scl_i, sda_i, host_addr,
                  output sda_oe, host_rdata, wr_pulse, wr_addr, wr_data, busy);
  modport master (output scl_i, sda_i, host_addr,
                  input  sda_oe, host_rdata, wr_pulse, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a 16x8 register bank, oversampled from clk.
// Define I2C_TGT_AUTOINC_EN to advance the pointer after every data byte.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input logic clk,
  input logic rst,
  i2c_target_regs_if.slave bus
);
`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ptr_q, ptr_d, wa_q, wa_d;
  logic [7:0] sh_q, sh_d, wd_q, wd_d, byte_in;
  logic rw_q, rw_d, ackd_q, ackd_d, oe_q, oe_d, busy_q, busy_d, wp_q, wp_d, we;
  logic [15:0][7:0] bank;
  logic scl_rise, scl_fall, start, stop;

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start    = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop     = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in  = {sh_q[6:0], sda_s2};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sh_d    = sh_q;
    rw_d    = rw_q;
    ackd_d  = ackd_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wp_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we      = 1'b0;
    if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      ackd_d  = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ackd_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            case (state_q)
              ADDR: if (byte_in[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
              PTR: begin
                ptr_d   = byte_in[3:0];
                state_d = PTR_ACK;
              end
              default: begin
                we      = 1'b1;
                wp_d    = 1'b1;
                wa_d    = ptr_q;
                wd_d    = byte_in;
                state_d = WDATA_ACK;
                if (AUTOINC) ptr_d = ptr_q + 4'd1;
              end
            endcase
          end
        end
        // ACK is a two-falling-edge window: pull low on the first, release on the second.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ackd_q) begin
            oe_d   = 1'b1;
            ackd_d = 1'b1;
          end else begin
            oe_d   = 1'b0;
            ackd_d = 1'b0;
            cnt_d  = 4'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              // The release edge is also where the first read bit goes out.
              state_d = RDATA;
              sh_d    = {bank[ptr_q][6:0], 1'b0};
              oe_d    = ~bank[ptr_q][7];
            end else if (state_q == ADDR_ACK) state_d = PTR;
            else state_d = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = RDATA_ACK;
              if (AUTOINC) ptr_d = ptr_q + 4'd1;
            end else begin
              oe_d = ~sh_q[7];
              sh_d = {sh_q[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: if (scl_rise) begin
          if (!sda_s2) begin
            state_d = RDATA;
            cnt_d   = 4'd0;
            sh_d    = bank[ptr_q];
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sh_q    <= '0;
      rw_q    <= 1'b0;
      ackd_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wp_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      bank    <= '0;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {bus.scl_i, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {bus.sda_i, sda_s1, sda_s2};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sh_q    <= sh_d;
      rw_q    <= rw_d;
      ackd_q  <= ackd_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      wp_q    <= wp_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      if (we) bank[ptr_q] <= byte_in;
    end
  end

  assign bus.sda_oe     = oe_q;
  assign bus.busy       = busy_q;
  assign bus.wr_pulse   = wp_q;
  assign bus.wr_addr    = wa_q;
  assign bus.wr_data    = wd_q;
  assign bus.host_rdata = bank[bus.host_addr];
endmodule

// File: tb/tb_i2c_target_regs.sv
// Random and directed I2C transactions against a register-bank model with wired-AND SDA.
module tb_i2c_target_regs;
  localparam logic [6:0] DEV = 7'h42;
  localparam int QC = 6;
`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  i2c_target_regs_if bus();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_target_regs #(.DEV_ADDR(DEV)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mregs [16];
  logic [3:0] mptr;
  logic [7:0] wbuf [4];
  logic [3:0] wl_a [512];
  logic [7:0] wl_d [512];
  int wr_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (bus.wr_pulse) begin
      if (wr_cnt < 512) begin
        wl_a[wr_cnt] = bus.wr_addr;
        wl_d[wr_cnt] = bus.wr_data;
      end
      wr_cnt++;
    end
    if (bus.sda_oe) oe_cnt++;
    if (bus.busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (QC) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); ack = bus.sda_i; q(); m_scl = 1'b0; q();
  endtask

  task automatic recv_byte(input logic ackb, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; q(); m_scl = 1'b1; q(); d = {d[6:0], bus.sda_i}; q(); m_scl = 1'b0; q();
    end
    m_sda = ackb; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
  endtask

  task automatic chk_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.host_addr = 4'(i);
      #1;
      chk(tag, {24'd0, bus.host_rdata}, {24'd0, mregs[i]});
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'd0;
  endtask

  // Address+W, pointer byte, n data bytes; model tracks bank, pointer and expected commits.
  task automatic wr_txn(input logic [3:0] p, input int n, input bit do_stop);
    logic a;
    logic [3:0] ea [4];
    logic [7:0] ed [4];
    int base;
    base = wr_cnt;
    i2c_start();
    send_byte({DEV, 1'b0}, a);
    chk("wr_addr_ack", {31'd0, a}, 32'd0);
    chk("busy_on", {31'd0, bus.busy}, 32'd1);
    send_byte({4'($urandom), p}, a);
    chk("ptr_ack", {31'd0, a}, 32'd0);
    mptr = p;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);
      chk("data_ack", {31'd0, a}, 32'd0);
      mregs[mptr] = wbuf[i];
      ea[i] = mptr;
      ed[i] = wbuf[i];
      if (AUTOINC) mptr = mptr + 4'd1;
    end
    if (do_stop) begin
      i2c_stop();
      chk("busy_off", {31'd0, bus.busy}, 32'd0);
    end
    chk("wr_count", 32'(wr_cnt - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", {28'd0, wl_a[base + i]}, {28'd0, ea[i]});
      chk("wr_data", {24'd0, wl_d[base + i]}, {24'd0, ed[i]});
    end
  endtask

  task automatic rd_txn(input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    send_byte({DEV, 1'b1}, a);
    chk("rd_addr_ack", {31'd0, a}, 32'd0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1), d);
      chk("rd_data", {24'd0, d}, {24'd0, mregs[mptr]});
      if (AUTOINC) mptr = mptr + 4'd1;
    end
    chk("nack_busy", {31'd0, bus.busy}, 32'd0);
    chk("nack_oe", {31'd0, bus.sda_oe}, 32'd0);
    i2c_stop();
  endtask

  initial begin
    logic a;
    int b0, o0, bz0;
    bus.host_addr = 4'd0;
    m_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wrp", {31'd0, bus.wr_pulse}, 32'd0);
    chk_bank("rst_bank");
    q();

    // Basic write: ptr 3, data A5
    wbuf[0] = 8'hA5;
    wr_txn(4'h3, 1, 1'b1);
    chk_bank("wr_basic");

    // Foreign address: no ACK, no busy, no commit
    b0 = wr_cnt; o0 = oe_cnt; bz0 = busy_cnt;
    i2c_start();
    send_byte({7'h50, 1'b0}, a);
    chk("foreign_nack", {31'd0, a}, 32'd1);
    send_byte(8'h12, a);
    i2c_stop();
    chk("foreign_oe", 32'(oe_cnt - o0), 32'd0);
    chk("foreign_busy", 32'(busy_cnt - bz0), 32'd0);
    chk("foreign_wr", 32'(wr_cnt - b0), 32'd0);

    // Pointer wrap at 15
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(4'hF, 2, 1'b1);
    chk_bank("wrap");

    // Write ptr, repeated START, read ACK then NACK
    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    wr_txn(4'h2, 2, 1'b1);
    wr_txn(4'h2, 0, 1'b0);
    rd_txn(2);

    // STOP after 4 data bits discards the byte
    b0 = wr_cnt;
    i2c_start();
    send_byte({DEV, 1'b0}, a);
    send_byte(8'h05, a);
    mptr = 4'h5;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    i2c_stop();
    chk("stop_wr", 32'(wr_cnt - b0), 32'd0);
    chk("stop_busy", {31'd0, bus.busy}, 32'd0);
    chk("stop_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk_bank("stop_bank");

    // Reset while the target pulls SDA for the address ACK
    i2c_start();
    for (int i = 6; i >= 0; i--) send_bit(DEV[i]);
    send_bit(1'b0);
    m_sda = 1'b1; q();
    chk("ack_drv", {31'd0, bus.sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ack_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("rst_ack_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    i2c_stop();

    // Reset mid data byte: no commit, bank cleared
    wbuf[0] = 8'h77;
    wr_txn(4'h9, 1, 1'b1);
    b0 = wr_cnt;
    i2c_start();
    send_byte({DEV, 1'b0}, a);
    send_byte(8'h07, a);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", {31'd0, bus.sda_oe}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk("rst_mid_wr", 32'(wr_cnt - b0), 32'd0);
    chk_bank("rst_mid_bank");
    i2c_stop();

    // Random mix of writes and reads
    for (int it = 0; it < 16; it++) begin
      int n;
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 2) != 2) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        wr_txn(4'($urandom), n, 1'b1);
      end else begin
        if ($urandom_range(0, 1) == 1) wr_txn(4'($urandom), 0, 1'b0);
        rd_txn(n);
      end
    end
    chk_bank("rand_bank");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, the 7-bit target address this block responds to.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port scl_i  input  1  bus SCL level, asynchronous to clk.
REQ-005 SHALL have port sda_i  input  1  bus SDA level, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-007 SHALL have port host_addr  input  4  local read index into the register bank.
REQ-008 SHALL have port host_rdata  output  8  combinational contents of the register at host_addr.
REQ-009 SHALL have port wr_pulse  output  1  one-cycle strobe per register written over I2C.
REQ-010 SHALL have port wr_addr  output  4  index of the committed write, valid with wr_pulse.
REQ-011 SHALL have port wr_data  output  8  data of the committed write, valid with wr_pulse.
REQ-012 SHALL have port busy  output  1  high from an addressed START until STOP or a NACK exit.

Function
REQ-013 SHALL pass scl_i and sda_i through 2-flop synchronizers plus one history flop; edge and START/STOP detection use the synchronized signals only.
REQ-014 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-015 SHALL hold a 16 x 8-bit register bank and a 4-bit pointer.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 SHALL shift SDA in MSB-first on each SCL rising edge in ADDR, PTR and WDATA, with 8 bits per byte.
REQ-018 SHALL, in ADDR after 8 bits, go to ADDR_ACK if bits[7:1]==DEV_ADDR, else to IDLE with sda_oe held 0.
REQ-019 SHALL drive ACK by asserting sda_oe on the SCL falling edge after bit 8 and releasing it on the following SCL falling edge.
REQ-020 SHALL, after the address ACK, go to PTR for R/W=0 and to RDATA for R/W=1.
REQ-021 SHALL load the pointer from byte bits[3:0] in PTR, with bits[7:4] ignored, then ACK and go to WDATA.
REQ-022 SHALL, per WDATA byte, write reg[pointer], pulse wr_pulse/wr_addr/wr_data once on the cycle the 8th bit is sampled, ACK, and return to WDATA.
REQ-023 SHALL, in RDATA, load reg[pointer] at state entry and present each bit on the SCL falling edge (sda_oe = ~bit), MSB first.
REQ-024 SHALL sample the initiator's ACK on the 9th SCL rising edge: ACK (0) -> next byte in RDATA; NACK (1) -> IDLE with sda_oe released.
REQ-025 SHALL, on START in any state (repeated START), go to ADDR, release sda_oe and keep the pointer.
REQ-026 SHALL, on STOP in any state, go to IDLE, release sda_oe and deassert busy; a partially received byte is discarded and not written.
REQ-027 SHALL, if START and a bit-shift qualify in the same clk, let START win.

Reset
REQ-028 SHALL, on rst, clear the state to IDLE, sda_oe/wr_pulse/busy to 0, wr_addr/wr_data/pointer to 0, every bank register to 8'h00, and the synchronizers to 1.
REQ-029 SHALL, on rst mid-transfer, abort with no write committed and SDA released in the next cycle.

Configuration
REQ-030 SHALL, with I2C_TGT_AUTOINC_EN defined, increment the pointer after each WDATA byte and each RDATA byte, wrapping 15 -> 0.
REQ-031 SHALL, without I2C_TGT_AUTOINC_EN, hold the pointer constant, so repeated bytes target the same register.

Verification
REQ-032 SHALL cover: write 0x84 (addr 0x42 W), ptr 0x03, data 0xA5 -> ACK on all 3 bytes, wr_pulse once with wr_addr=3/wr_data=0xA5, host_addr=3 reads 0xA5.
REQ-033 SHALL cover: address 0x50 W -> no ACK (sda_oe stays 0), busy stays 0, no wr_pulse.
REQ-034 SHALL cover: ptr 0x0F, data 0x11, 0x22 with AUTOINC -> reg15=0x11, reg0=0x22; without AUTOINC -> reg15=0x22.
REQ-035 SHALL cover: write ptr 0x02, repeated START, 0x85 read, 2 bytes (ACK, NACK) -> reg2 then reg3 on SDA (AUTOINC), then IDLE.
REQ-036 SHALL cover: STOP after 4 data bits, and rst asserted mid-byte -> no wr_pulse, sda_oe=0, state IDLE, bank unchanged (or cleared by rst).
